// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, valid/ready IR.
// Optional HALT on type 2'b11 when IFU_HALT_EN is defined.
module instr_fetch_unit #(
  parameter int              ADDR_W      = 32,
  parameter int              INSTR_W     = 32,
  parameter int              INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [1:0]         instruction_type,
  output logic [4:0]         func,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

`ifdef IFU_HALT_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD} state_t;
`endif

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               drop_q, drop_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pco_q, pco_d;
`ifdef IFU_HALT_EN
  logic               halt_q, halt_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    pco_d   = pco_q;
`ifdef IFU_HALT_EN
    halt_d  = halt_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) pc_d = redirect_pc;
      end
      REQ: begin
        state_d = WAIT;
        // a stale response can land here after a redirect re-issue
        if (imem_rvalid && drop_q) drop_d = 1'b0;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          drop_d  = 1'b1;
          state_d = REQ;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          drop_d  = !imem_rvalid;
          state_d = REQ;
        end else if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d = imem_rdata;
            pco_d   = pc_q;
            pc_d    = pc_q + ADDR_W'(INSTR_BYTES);
            vld_d   = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          vld_d   = 1'b0;
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (if_ready) begin
          vld_d   = 1'b0;
          state_d = REQ;
`ifdef IFU_HALT_EN
          if (instr_q[INSTR_W-1 -: 2] == 2'b11) begin
            state_d = HALT;
            halt_d  = 1'b1;
          end
`endif
        end
      end
`ifdef IFU_HALT_EN
      HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          halt_d  = 1'b0;
          state_d = REQ;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == REQ);
    addr_d = req_d ? pc_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      instr_q <= '0;
      pco_q   <= '0;
`ifdef IFU_HALT_EN
      halt_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
`ifdef IFU_HALT_EN
      halt_q  <= halt_d;
`endif
    end
  end

  assign imem_req         = req_q;
  assign imem_addr        = addr_q;
  assign if_valid         = vld_q;
  assign instr            = instr_q;
  assign instruction_type = instr_q[INSTR_W-1 -: 2];
  assign func             = instr_q[INSTR_W-3 -: 5];
  assign pc_out           = pco_q;
`ifdef IFU_HALT_EN
  assign halted           = halt_q;
`else
  assign halted           = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table plus reset/wrap/halt
// sequences. Define IFU_HALT_EN to exercise the HALT feature.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] instr;
  logic [1:0]  instruction_type;
  logic [4:0]  func;
  logic [31:0] pc_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .instr            (instr),
    .instruction_type (instruction_type),
    .func             (func),
    .pc_out           (pc_out),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [1:0]  e_typ;
    logic [4:0]  e_fn;
  } vec_t;

  vec_t v [22];

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int reqs;
    v[0]  = '{0, 32'h0,         0, 0, 32'h0,   1, 32'h0,   0, 32'h0,  2'd0, 5'h00};
    v[1]  = '{0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   0, 32'h0,  2'd0, 5'h00};
    v[2]  = '{1, 32'h8000_0000, 1, 0, 32'h0,   0, 32'h0,   1, 32'h0,  2'd2, 5'h00};
    v[3]  = '{0, 32'h0,         1, 0, 32'h0,   1, 32'h4,   0, 32'h0,  2'd2, 5'h00};
    v[4]  = '{0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   0, 32'h0,  2'd2, 5'h00};
    v[5]  = '{1, 32'h4A00_0000, 0, 0, 32'h0,   0, 32'h0,   1, 32'h4,  2'd1, 5'h05};
    for (int i = 6; i <= 10; i++)
      v[i] = '{0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 32'h4,  2'd1, 5'h05};
    v[11] = '{0, 32'h0,         1, 0, 32'h0,   1, 32'h8,   0, 32'h4,  2'd1, 5'h05};
    v[12] = '{0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   0, 32'h4,  2'd1, 5'h05};
    v[13] = '{0, 32'h0,         0, 1, 32'h40,  1, 32'h40,  0, 32'h4,  2'd1, 5'h05};
    v[14] = '{0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   0, 32'h4,  2'd1, 5'h05};
    v[15] = '{1, 32'hDEAD_BEEF, 0, 0, 32'h0,   1, 32'h40,  0, 32'h4,  2'd1, 5'h05};
    v[16] = '{0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   0, 32'h4,  2'd1, 5'h05};
    v[17] = '{1, 32'h1234_5678, 0, 0, 32'h0,   0, 32'h0,   1, 32'h40, 2'd0, 5'h09};
    v[18] = '{0, 32'h0,         1, 1, 32'h100, 1, 32'h100, 0, 32'h40, 2'd0, 5'h09};
    v[19] = '{0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   0, 32'h40, 2'd0, 5'h09};
    v[20] = '{1, 32'h87C0_0000, 0, 0, 32'h0,   0, 32'h0,   1, 32'h100,2'd2, 5'h03};
    v[21] = '{0, 32'h0,         1, 0, 32'h0,   1, 32'h104, 0, 32'h100,2'd2, 5'h03};

    rst = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    step();
    chk("rst_req",    32'(imem_req), 32'd0);
    chk("rst_addr",   imem_addr,     32'd0);
    chk("rst_valid",  32'(if_valid), 32'd0);
    chk("rst_pc_out", pc_out,        32'd0);
    chk("rst_instr",  instr,         32'd0);
    chk("rst_halted", 32'(halted),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      imem_rvalid    = v[i].rv;
      imem_rdata     = v[i].rd;
      if_ready       = v[i].rdy;
      redirect_valid = v[i].redir;
      redirect_pc    = v[i].rpc;
      step();
      chk($sformatf("row%0d_req", i),   32'(imem_req),  32'(v[i].e_req));
      chk($sformatf("row%0d_addr", i),  imem_addr,      v[i].e_addr);
      chk($sformatf("row%0d_valid", i), 32'(if_valid),  32'(v[i].e_vld));
      chk($sformatf("row%0d_pc", i),    pc_out,         v[i].e_pc);
      chk($sformatf("row%0d_type", i),  32'(instruction_type), 32'(v[i].e_typ));
      chk($sformatf("row%0d_func", i),  32'(func),      32'(v[i].e_fn));
      chk($sformatf("row%0d_halt", i),  32'(halted),    32'd0);
    end
    imem_rvalid = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;

    // PC wrap: fetch at 0xFFFF_FFFC, next sequential address is 0
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_0001;
    step();
    chk("wrap_hold_pc", pc_out, 32'h104);
    imem_rvalid = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req_valid", 32'(if_valid), 32'd0);
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h4000_0000;
    step();
    imem_rvalid = 1'b0;
    chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    chk("wrap_valid", 32'(if_valid), 32'd1);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    chk("wrap_next_req", 32'(imem_req), 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Asynchronous reset in WAIT, stale rvalid right after release
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_pc_out", pc_out, 32'd0);
    chk("async_rst_instr", instr, 32'd0);
    step();
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0000;
    step();
    imem_rvalid = 1'b0;
    chk("stale_req", 32'(imem_req), 32'd1);
    chk("stale_addr", imem_addr, 32'h0);
    chk("stale_valid", 32'(if_valid), 32'd0);
    step();
    chk("stale_wait_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h4000_0000;
    step();
    imem_rvalid = 1'b0;
    chk("post_rst_valid", 32'(if_valid), 32'd1);
    chk("post_rst_pc", pc_out, 32'h0);
    chk("post_rst_instr", instr, 32'h4000_0000);

    // Type 2'b11 word
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    chk("t3_req_addr", imem_addr, 32'h4);
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hC000_0000;
    step();
    imem_rvalid = 1'b0;
    chk("t3_valid", 32'(if_valid), 32'd1);
    chk("t3_type", 32'(instruction_type), 32'd3);
    chk("t3_pc", pc_out, 32'h4);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    chk("t3_consumed", 32'(if_valid), 32'd0);
`ifdef IFU_HALT_EN
    chk("halt_set", 32'(halted), 32'd1);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) reqs++;
      step();
    end
    chk("halt_no_req", 32'(reqs), 32'd0);
    chk("halt_held", 32'(halted), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("halt_exit", 32'(halted), 32'd0);
    chk("halt_exit_req", 32'(imem_req), 32'd1);
    chk("halt_exit_addr", imem_addr, 32'h10);
`else
    reqs = 0;
    chk("nohalt_halted", 32'(halted), 32'd0);
    chk("nohalt_req", 32'(imem_req), 32'd1);
    chk("nohalt_addr", imem_addr, 32'h8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
